sensor_acq_sequencer: RTL and testbench

SENSOR_ACQ_SEQUENCER -- requirements
Module: sensor_acq_sequencer

---
 rtl/sensor_acq_sequencer_pkg.sv | 24 ++
 rtl/cycle_down_counter.sv | 31 +++
 rtl/sensor_acq_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sensor_acq_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_acq_sequencer_pkg.sv
// Shared types and widths for the sensor acquisition sequencer.
// Holds the FSM state encoding, counter widths and sample-count helper.
package sensor_acq_sequencer_pkg;

  localparam int CNT_W  = 16;
  localparam int SAMP_W = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } acq_state_e;

  // A request for zero samples still takes one.
  function automatic logic [SAMP_W-1:0] eff_samples(
    input logic [SAMP_W-1:0] n
  );
    return (n == '0) ? SAMP_W'(1) : n;
  endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down counter that stops at zero and flags it.
// Ports: clk, rst_n, load/load_val, dec, zero.
module cycle_down_counter
  import sensor_acq_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sensor_acq_sequencer.sv
// Sensor acquisition sequencer: trigger -> delay -> N x (acq_start, wait).
// Ports: clk, rst_n, enable, trigger, start_delay, timeout_cycles,
//   num_samples, sample_valid, clear_err -> acq_start, done, busy,
//   sample_count, acq_cycles, timeout_err, overrun_err.
module sensor_acq_sequencer
  import sensor_acq_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  start_delay,
  input  logic [CNT_W-1:0]  timeout_cycles,
  input  logic [SAMP_W-1:0] num_samples,
  input  logic              sample_valid,
  input  logic              clear_err,
  output logic              acq_start,
  output logic              done,
  output logic              busy,
  output logic [SAMP_W-1:0] sample_count,
  output logic [CNT_W-1:0]  acq_cycles,
  output logic              timeout_err,
  output logic              overrun_err
);

  acq_state_e state;

  logic              accept;
  logic              dly_load;
  logic              dly_dec;
  logic              dly_zero;
  logic [CNT_W-1:0]  dly_val;
  logic              to_load;
  logic              to_dec;
  logic              to_zero;
  logic [CNT_W-1:0]  to_val;
  logic              to_en;
  logic              timeout_hit;
  logic              sample_last;
  logic [SAMP_W-1:0] next_count;

  assign accept = (state == ST_IDLE) && trigger && enable;

  // Counters are loaded with N-1 so that the zero flag marks the last
  // cycle of the interval and the transition lands exactly on time.
  assign dly_load = accept;
  assign dly_val  = start_delay - CNT_W'(1);
  assign dly_dec  = (state == ST_DELAY);

  assign to_load = (state == ST_ISSUE);
  assign to_val  = timeout_cycles - CNT_W'(1);
  assign to_dec  = (state == ST_WAIT);

  assign next_count  = sample_count + SAMP_W'(1);
  assign sample_last = (next_count == eff_samples(num_samples));

  // A sample in the expiry cycle wins; an abort wins over both.
  assign timeout_hit = (state == ST_WAIT) && enable &&
                       !sample_valid && to_en && to_zero;

  cycle_down_counter #(
    .W (CNT_W)
  ) u_delay_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (dly_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  cycle_down_counter #(
    .W (CNT_W)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .load_val (to_val),
    .dec      (to_dec),
    .zero     (to_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      acq_start    <= 1'b0;
      done         <= 1'b1;
      busy         <= 1'b0;
      sample_count <= '0;
      acq_cycles   <= '0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
      to_en        <= 1'b0;
    end else begin
      acq_start <= 1'b0;

      if (trigger && (state != ST_IDLE)) begin
        overrun_err <= 1'b1;
      end else if (clear_err) begin
        overrun_err <= 1'b0;
      end

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end

      if ((state != ST_IDLE) && (acq_cycles != CNT_MAX)) begin
        acq_cycles <= acq_cycles + CNT_W'(1);
      end

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            sample_count <= '0;
            acq_cycles   <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            if (start_delay == '0) begin
              state     <= ST_ISSUE;
              acq_start <= 1'b1;
            end else begin
              state <= ST_DELAY;
            end
          end
        end

        ST_DELAY: begin
          if (!enable) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (dly_zero) begin
            state     <= ST_ISSUE;
            acq_start <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (!enable) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= ST_WAIT;
            to_en <= (timeout_cycles != '0);
          end
        end

        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (sample_valid) begin
            sample_count <= next_count;
            if (sample_last) begin
              state <= ST_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= ST_ISSUE;
              acq_start <= 1'b1;
            end
          end else if (timeout_hit) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_acq_sequencer.sv
// Self-checking bench for sensor_acq_sequencer.
// Timeline model per acquisition, directed and random scenarios.
module tb_sensor_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] start_delay = '0;
  logic [15:0] timeout_cycles = '0;
  logic [3:0]  num_samples = '0;
  logic        sample_valid = 1'b0;
  logic        clear_err = 1'b0;
  logic        acq_start;
  logic        done;
  logic        busy;
  logic [3:0]  sample_count;
  logic [15:0] acq_cycles;
  logic        timeout_err;
  logic        overrun_err;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int lat[16];

  always #5 clk = ~clk;

  sensor_acq_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .trigger        (trigger),
    .start_delay    (start_delay),
    .timeout_cycles (timeout_cycles),
    .num_samples    (num_samples),
    .sample_valid   (sample_valid),
    .clear_err      (clear_err),
    .acq_start      (acq_start),
    .done           (done),
    .busy           (busy),
    .sample_count   (sample_count),
    .acq_cycles     (acq_cycles),
    .timeout_err    (timeout_err),
    .overrun_err    (overrun_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Plans one acquisition as absolute cycle numbers, drives it and
  // checks every output each cycle. ovr_off/drop_off: 0 none,
  // >0 offset from trigger, <0 random non-idle cycle.
  task automatic run_acq(input int sd, input int ns, input int to,
                         input int ovr_off, input int drop_off,
                         input string nm);
    int starts[16];
    int svs[16];
    int n_st, n_sv, t0, d, e, ovr_c, a, eff, l;
    int exp_sc, exp_cyc;
    bit terr, clr_ovr, exp_st, exp_done, exp_to, exp_ov, is_sv, strayok;
    eff = (ns == 0) ? 1 : ns;
    t0 = cyc;
    a = t0 + 1 + sd;
    n_st = 0;
    n_sv = 0;
    terr = 0;
    d = 0;
    for (int k = 0; k < eff; k++) begin
      starts[n_st] = a;
      n_st++;
      l = lat[k];
      if (to != 0 && l > to) begin
        d = a + to + 1;
        terr = 1;
        break;
      end
      svs[n_sv] = a + l;
      n_sv++;
      if (k == eff - 1) d = a + l + 1;
      else a = a + l + 1;
    end
    e = 0;
    if (drop_off > 0) e = t0 + drop_off;
    else if (drop_off < 0) e = t0 + 1 + int'($urandom_range(0, d - t0 - 2));
    if (e >= d) e = 0;
    if (e != 0) begin
      d = e + 1;
      terr = 0;
    end
    ovr_c = 0;
    if (ovr_off > 0) ovr_c = t0 + ovr_off;
    else if (ovr_off < 0) ovr_c = t0 + 1 + int'($urandom_range(0, d - t0 - 2));
    if (ovr_c >= d) ovr_c = 0;
    clr_ovr = 1'($urandom_range(0, 1));
    start_delay = 16'(sd);
    num_samples = 4'(ns);
    timeout_cycles = 16'(to);
    enable = 1'b1;
    for (int c = t0; c <= d + 2; c++) begin
      if (c > t0 && ((c - t0) < 40 || (d - c) < 40)) begin
        exp_st = 0;
        for (int j = 0; j < n_st; j++)
          if (starts[j] == c && (e == 0 || c <= e)) exp_st = 1;
        exp_sc = 0;
        for (int j = 0; j < n_sv; j++)
          if (svs[j] < c && (e == 0 || svs[j] < e)) exp_sc++;
        exp_cyc = ((c < d) ? c : d) - t0 - 1;
        if (exp_cyc > 65535) exp_cyc = 65535;
        exp_done = (c >= d);
        exp_to = terr && (c >= d);
        exp_ov = (ovr_c != 0) && (c > ovr_c);
        vec++;
        if (acq_start !== exp_st) begin
          miss++;
          $display("FAIL %s/acq_start t+%0d got %b exp %b", nm, c - t0, acq_start, exp_st);
        end
        vec++;
        if (done !== exp_done) begin
          miss++;
          $display("FAIL %s/done t+%0d got %b exp %b", nm, c - t0, done, exp_done);
        end
        vec++;
        if (busy !== !exp_done) begin
          miss++;
          $display("FAIL %s/busy t+%0d got %b exp %b", nm, c - t0, busy, !exp_done);
        end
        vec++;
        if (sample_count !== 4'(exp_sc)) begin
          miss++;
          $display("FAIL %s/sample_count t+%0d got %0d exp %0d", nm, c - t0, sample_count, exp_sc);
        end
        vec++;
        if (acq_cycles !== 16'(exp_cyc)) begin
          miss++;
          $display("FAIL %s/acq_cycles t+%0d got %0d exp %0d", nm, c - t0, acq_cycles, exp_cyc);
        end
        vec++;
        if (timeout_err !== exp_to) begin
          miss++;
          $display("FAIL %s/timeout_err t+%0d got %b exp %b", nm, c - t0, timeout_err, exp_to);
        end
        vec++;
        if (overrun_err !== exp_ov) begin
          miss++;
          $display("FAIL %s/overrun_err t+%0d got %b exp %b", nm, c - t0, overrun_err, exp_ov);
        end
      end
      trigger = (c == t0) || (c == ovr_c);
      clear_err = (c == t0) || (c == ovr_c && clr_ovr);
      enable = !(e != 0 && c >= e);
      is_sv = 0;
      for (int j = 0; j < n_sv; j++)
        if (svs[j] == c) is_sv = 1;
      strayok = (c > t0 && c <= t0 + sd) || (c >= d);
      for (int j = 0; j < n_st; j++)
        if (starts[j] == c) strayok = 1;
      sample_valid = is_sv || (strayok && $urandom_range(0, 2) == 0);
      step();
    end
    trigger = 1'b0;
    clear_err = 1'b0;
    sample_valid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    step();
    step();
    vec++;
    if ({done, busy, acq_start} !== 3'b100) begin
      miss++;
      $display("FAIL reset/ctrl got %b exp 100", {done, busy, acq_start});
    end
    vec++;
    if ({sample_count, acq_cycles, timeout_err, overrun_err} !== 22'd0) begin
      miss++;
      $display("FAIL reset/data got %0h exp 0", {sample_count, acq_cycles, timeout_err, overrun_err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    lat = '{default: 5};
    run_acq(3, 2, 0, 0, 0, "basic");
  endtask

  task automatic test_timeout();
    lat = '{default: 20};
    run_acq(2, 1, 10, 0, 0, "timeout");
  endtask

  task automatic test_tie();
    lat = '{default: 4};
    run_acq(1, 2, 4, 0, 0, "tie");
  endtask

  task automatic test_overrun();
    lat = '{default: 3};
    lat[1] = 6;
    lat[2] = 12;
    run_acq(4, 3, 8, 6, 0, "overrun");
  endtask

  task automatic test_clear();
    vec++;
    if ({timeout_err, overrun_err} !== 2'b11) begin
      miss++;
      $display("FAIL clear/pre got %b exp 11", {timeout_err, overrun_err});
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    vec++;
    if ({timeout_err, overrun_err} !== 2'b00) begin
      miss++;
      $display("FAIL clear/post got %b exp 00", {timeout_err, overrun_err});
    end
  endtask

  task automatic test_abort();
    lat = '{default: 4};
    run_acq(2, 3, 0, 0, 10, "abort");
  endtask

  task automatic test_disabled();
    enable = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vec++;
      if ({acq_start, done, busy} !== 3'b010) begin
        miss++;
        $display("FAIL disabled/ctrl i=%0d got %b exp 010", i, {acq_start, done, busy});
      end
      step();
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_delay();
    enable = 1'b1;
    start_delay = 16'd8;
    num_samples = 4'd1;
    timeout_cycles = 16'd0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({done, busy, acq_start} !== 3'b100) begin
      miss++;
      $display("FAIL rstmid/ctrl got %b exp 100", {done, busy, acq_start});
    end
    vec++;
    if ({sample_count, acq_cycles, timeout_err, overrun_err} !== 22'd0) begin
      miss++;
      $display("FAIL rstmid/data got %0h exp 0", {sample_count, acq_cycles, timeout_err, overrun_err});
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      vec++;
      if ({acq_start, done} !== 2'b01) begin
        miss++;
        $display("FAIL rstmid/after i=%0d got %b exp 01", i, {acq_start, done});
      end
    end
  endtask

  task automatic test_zero_delay();
    lat = '{default: 3};
    run_acq(0, 1, 0, 0, 0, "zero_delay");
  endtask

  task automatic test_num_zero();
    lat = '{default: 2};
    run_acq(1, 0, 5, 0, 0, "num_zero");
  endtask

  task automatic test_random();
    int sd, ns, to, ov, dr;
    for (int it = 0; it < 40; it++) begin
      sd = int'($urandom_range(0, 6));
      ns = int'($urandom_range(0, 5));
      to = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
      for (int k = 0; k < 16; k++)
        lat[k] = int'($urandom_range(1, (to != 0) ? to + 3 : 12));
      ov = ($urandom_range(0, 2) == 0) ? -1 : 0;
      dr = ($urandom_range(0, 3) == 0) ? -1 : 0;
      run_acq(sd, ns, to, ov, dr, "random");
    end
  endtask

  task automatic test_saturate();
    lat = '{default: 5};
    run_acq(65535, 1, 0, 0, 0, "saturate");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_tie();
    test_overrun();
    test_clear();
    test_abort();
    test_disabled();
    test_reset_mid_delay();
    test_zero_delay();
    test_num_zero();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
